// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: FSM state encoding and frame constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2State_t;

  localparam int   PS2_DATA_BITS = 8;
  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead byte FIFO for received scan codes; rdData reads 0 while empty.
module ps2_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               pushData,
  input  logic                     pop,
  output logic [7:0]               rdData,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign doPush = push && (!full || doPop);
  assign rdData = empty ? 8'h00 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: sync, glitch filter, frame FSM and byte FIFO.
// Optional frame timeout enabled by defining PS2_RECEIVER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit on a filtered falling edge
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then push or report
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2c,
  input  logic                          ps2d,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    ps2cSync;
  logic [1:0]    ps2dSync;
  logic          ps2cS;
  logic          ps2dS;
  logic          filtClk;
  logic          filtClkD;
  logic [FW-1:0] filtCnt;
  logic          fall;

  ps2State_t     state;
  ps2State_t     stateNext;
  logic [7:0]    shiftReg;
  logic [7:0]    shiftNext;
  logic [2:0]    bitIdx;
  logic [2:0]    idxNext;
  logic          parityBit;
  logic          parNext;
  logic          badPar;
  logic          badStop;
  logic          pushReq;
  logic          parErrNext;
  logic          frmErrNext;
  logic          ovfNext;
  logic          pop;
  logic          timeoutHit;

  assign ps2cS = ps2cSync[1];
  assign ps2dS = ps2dSync[1];
  assign fall  = filtClkD && !filtClk;
  assign pop   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      ps2cSync <= 2'b11;
      ps2dSync <= 2'b11;
    end else begin
      ps2cSync <= {ps2cSync[0], ps2c};
      ps2dSync <= {ps2dSync[0], ps2d};
    end
  end

  // Filtered clock only follows a level that has differed for FILTER_LEN straight cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      filtClk  <= 1'b1;
      filtClkD <= 1'b1;
      filtCnt  <= '0;
    end else begin
      filtClkD <= filtClk;
      if (ps2cS == filtClk) begin
        filtCnt <= '0;
      end else if (filtCnt == FW'(FILTER_LEN - 1)) begin
        filtClk <= ps2cS;
        filtCnt <= '0;
      end else begin
        filtCnt <= filtCnt + 1'b1;
      end
    end
  end

`ifdef PS2_RECEIVER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] toTimer;

  // Down-counter reloaded on every fall; terminal count while mid-frame means the device stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      toTimer <= '0;
    end else if (state == IDLE || fall) begin
      toTimer <= TW'(TIMEOUT_CYCLES - 1);
    end else if (toTimer != '0) begin
      toTimer <= toTimer - 1'b1;
    end
  end

  assign timeoutHit = (state != IDLE) && !fall && (toTimer == '0);
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES > 0);
  assign timeoutHit       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      bitIdx     <= '0;
      parityBit  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= stateNext;
      shiftReg   <= shiftNext;
      bitIdx     <= idxNext;
      parityBit  <= parNext;
      parity_err <= parErrNext;
      frame_err  <= frmErrNext;
      overflow   <= ovfNext;
    end
  end

  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    idxNext    = bitIdx;
    parNext    = parityBit;
    badPar     = 1'b0;
    badStop    = 1'b0;
    pushReq    = 1'b0;
    parErrNext = 1'b0;
    frmErrNext = 1'b0;
    ovfNext    = 1'b0;

    if (fall) begin
      case (state)
        IDLE: begin
          if (ps2dS == PS2_START_BIT) begin
            stateNext = DATA;
            idxNext   = '0;
          end
        end
        DATA: begin
          shiftNext = {ps2dS, shiftReg[7:1]};
          if (bitIdx == 3'(PS2_DATA_BITS - 1)) begin
            stateNext = PARITY;
          end else begin
            idxNext = bitIdx + 1'b1;
          end
        end
        PARITY: begin
          parNext   = ps2dS;
          stateNext = STOP;
        end
        STOP: begin
          badPar     = !((^shiftReg) ^ parityBit);
          badStop    = (ps2dS != PS2_STOP_BIT);
          parErrNext = badPar;
          frmErrNext = badStop;
          if (!badPar && !badStop) begin
            if (!full || pop) pushReq = 1'b1;
            else              ovfNext = 1'b1;
          end
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end

    if (timeoutHit) begin
      stateNext  = IDLE;
      idxNext    = '0;
      frmErrNext = 1'b1;
    end
  end

  ps2_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushReq),
    .pushData (shiftReg),
    .pop      (rd_en),
    .rdData   (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

endmodule
